// File: rtl/audio_avg_filter.sv
// Stereo moving-average filter: N-tap running sum per channel over a circular delay buffer.
// Optional raw-sample bypass port enabled by defining AVG_FILTER_BYPASS_EN.
module audio_avg_filter #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
`ifdef AVG_FILTER_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int N = 1 << LOG2_N;

  typedef enum logic [2:0] {
    S_WAIT_RD = 3'd0,
    S_POP     = 3'd1,
    S_ACC     = 3'd2,
    S_WAIT_WR = 3'd3,
    S_PUSH    = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic signed [DATA_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [DATA_W-1:0]  buf_l_q [N];
  logic signed [DATA_W-1:0]  buf_l_d [N];
  logic signed [DATA_W-1:0]  buf_r_q [N];
  logic signed [DATA_W-1:0]  buf_r_d [N];
  logic        [LOG2_N-1:0]  ptr_q, ptr_d;
  logic                      read_q, read_d, write_q, write_d;
  logic        [DATA_W-1:0]  wd_l_q, wd_l_d, wd_r_q, wd_r_d;
  logic signed [DATA_W-1:0]  scaled_l, scaled_r;
  logic                      use_raw;

  // Each tap is pre-divided by N so the N-term sum stays within DATA_W.
  assign scaled_l = smp_l_q >>> LOG2_N;
  assign scaled_r = smp_r_q >>> LOG2_N;

`ifdef AVG_FILTER_BYPASS_EN
  assign use_raw = bypass;
`else
  assign use_raw = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    smp_l_d = smp_l_q;
    smp_r_d = smp_r_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    ptr_d   = ptr_q;
    wd_l_d  = wd_l_q;
    wd_r_d  = wd_r_q;
    case (state_q)
      S_WAIT_RD: begin
        if (read_ready) begin
          smp_l_d = $signed(readdata_left);
          smp_r_d = $signed(readdata_right);
          state_d = S_POP;
        end else begin
          state_d = S_WAIT_RD;
        end
      end
      S_POP: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_l_d        = acc_l_q + scaled_l - buf_l_q[ptr_q];
        acc_r_d        = acc_r_q + scaled_r - buf_r_q[ptr_q];
        buf_l_d[ptr_q] = scaled_l;
        buf_r_d[ptr_q] = scaled_r;
        ptr_d          = ptr_q + 1'b1;
        state_d        = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (write_ready) begin
          if (use_raw) begin
            wd_l_d = smp_l_q;
            wd_r_d = smp_r_q;
          end else begin
            wd_l_d = acc_l_q;
            wd_r_d = acc_r_q;
          end
          state_d = S_PUSH;
        end else begin
          state_d = S_WAIT_WR;
        end
      end
      S_PUSH: begin
        state_d = S_WAIT_RD;
      end
      default: begin
        state_d = S_WAIT_RD;
      end
    endcase
    // Pulses are registered alongside the state they belong to, so they last exactly one cycle.
    read_d  = (state_d == S_POP);
    write_d = (state_d == S_PUSH);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT_RD;
      smp_l_q <= '0;
      smp_r_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      for (int i = 0; i < N; i++) begin
        buf_l_q[i] <= '0;
        buf_r_q[i] <= '0;
      end
      ptr_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
    end else begin
      state_q <= state_d;
      smp_l_q <= smp_l_d;
      smp_r_q <= smp_r_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      ptr_q   <= ptr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wd_l_q  <= wd_l_d;
      wd_r_q  <= wd_r_d;
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;

endmodule
